// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads over req/ack, buffers
// returned {word, address} pairs and hands them to the IR. FETCH_PREFETCH_EN selects a 2-deep buffer.
//
// state   | meaning
// S_IDLE  | no request outstanding
// S_REQ   | request outstanding at MemAddr; acked data is pushed
// S_DRAIN | stale request outstanding after a branch; acked data is dropped
module instr_fetch #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 24
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 FetchEn,
   input  logic                 BranchEn,
   input  logic [AddrWidth-1:0] BranchAddr,
   output logic                 MemReq,
   output logic [AddrWidth-1:0] MemAddr,
   input  logic                 MemAck,
   input  logic [DataWidth-1:0] MemDataIn,
   output logic                 IRInEn,
   input  logic                 IRReady,
   output logic [DataWidth-1:0] IRDataOut,
   output logic [AddrWidth-1:0] PCOut
);

`ifdef FETCH_PREFETCH_EN
   localparam logic [1:0] Depth = 2'd2;
`else
   localparam logic [1:0] Depth = 2'd1;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DRAIN
   } state_t;

   state_t               state;
   logic                 mem_req;
   logic [AddrWidth-1:0] mem_addr;
   logic [AddrWidth-1:0] pc;

   // Two slots always exist; with Depth=1 the pointers never leave slot 0.
   logic [DataWidth-1:0] word_q [2];
   logic [AddrWidth-1:0] addr_q [2];
   logic                 rd_ptr;
   logic                 wr_ptr;
   logic [1:0]           count;

   logic                 pop;
   logic                 ack;
   logic                 push;
   logic [1:0]           count_pop;
   logic [1:0]           count_nxt;
   logic [AddrWidth-1:0] pc_nxt;
   logic                 fetch_ok;

   always_comb begin
      pop       = (count != 2'd0) && IRReady;
      ack       = mem_req && MemAck;
      push      = ack && (state == S_REQ) && !BranchEn;
      count_pop = count - {1'b0, pop};
      count_nxt = BranchEn ? 2'd0 : (count_pop + {1'b0, push});
      if (BranchEn)
         pc_nxt = BranchAddr;
      else if (push)
         pc_nxt = pc + {{(AddrWidth-1){1'b0}}, 1'b1};
      else
         pc_nxt = pc;
      fetch_ok  = FetchEn && (count_nxt < Depth);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         pc       <= '0;
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            word_q[i] <= '0;
            addr_q[i] <= '0;
         end
      end else begin
         pc    <= pc_nxt;
         count <= count_nxt;

         if (push) begin
            word_q[wr_ptr] <= MemDataIn;
            addr_q[wr_ptr] <= mem_addr;
         end

         if (BranchEn) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
         end else begin
            if (pop)
               rd_ptr <= (Depth == 2'd2) ? ~rd_ptr : 1'b0;
            if (push)
               wr_ptr <= (Depth == 2'd2) ? ~wr_ptr : 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (fetch_ok) begin
                  state    <= S_REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= pc_nxt;
               end
            end
            S_REQ, S_DRAIN: begin
               // The request is held until acked; a branch only changes what the ack means.
               if (ack) begin
                  if (fetch_ok) begin
                     state    <= S_REQ;
                     mem_addr <= pc_nxt;
                  end else begin
                     state    <= S_IDLE;
                     mem_req  <= 1'b0;
                  end
               end else if (BranchEn) begin
                  state <= S_DRAIN;
               end
            end
            default: begin
               state   <= S_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign MemReq    = mem_req;
   assign MemAddr   = mem_addr;
   assign IRInEn    = (count != 2'd0);
   assign IRDataOut = word_q[rd_ptr];
   assign PCOut     = addr_q[rd_ptr];

endmodule
